// File: rtl/out_fifo_pkg.sv
// Shared width helpers for the PHY output FIFO.
package out_fifo_pkg;

  function automatic int qw_width(input int narrow, input int din_w);
    if (narrow != 0) begin
      return din_w / 2;
    end else begin
      return din_w;
    end
  endfunction

  function automatic int ptr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_fifo_mem.sv
// Storage array for the output FIFO: one synchronous write port, one asynchronous read port.
module out_fifo_mem
  import out_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 80,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/out_fifo_sync.sv
// Single-clock output FIFO with optional 2:1 per-channel serialisation, occupancy
// count, registered threshold flags and overflow/underflow pulses.
module out_fifo_sync
  import out_fifo_pkg::*;
#(
  parameter int CHANNELS       = 10,
  parameter int DIN_W          = 8,
  parameter int DEPTH          = 8,
  parameter int AE_LEVEL       = 1,
  parameter int AF_LEVEL       = 1,
  parameter int NARROW_MODE    = 1,
  parameter int OUTPUT_DISABLE = 0
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic                                           i_wren,
  input  logic [CHANNELS*DIN_W-1:0]                      i_d,
  input  logic                                           i_rden,
  output logic [CHANNELS*qw_width(NARROW_MODE,DIN_W)-1:0] o_q,
  output logic                                           o_empty,
  output logic                                           o_almost_empty,
  output logic                                           o_full,
  output logic                                           o_almost_full,
  output logic [cnt_width(DEPTH)-1:0]                    o_count,
  output logic                                           o_overflow,
  output logic                                           o_underflow
);

  localparam int QW     = qw_width(NARROW_MODE, DIN_W);
  localparam int PW     = ptr_width(DEPTH);
  localparam int CW     = cnt_width(DEPTH);
  localparam int W      = CHANNELS * DIN_W;
  localparam int HOFS   = (NARROW_MODE != 0) ? QW : 0;
  localparam int AE_THR = (AE_LEVEL > DEPTH) ? DEPTH : AE_LEVEL;
  localparam int AF_THR = (AF_LEVEL >= DEPTH) ? 0 : DEPTH - AF_LEVEL;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THR);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THR);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic          AF_RST   = (AF_LEVEL >= DEPTH) ? 1'b1 : 1'b0;

  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic                 phase_r;
  logic [CHANNELS*QW-1:0] q_r;
  logic                 empty_r, ae_r, full_r, af_r, ovf_r, udf_r;

  logic                 rd_ok_s, pop_s, wr_ok_s, phase_nxt_s;
  logic [CW-1:0]        count_nxt_s;
  logic [W-1:0]         rd_word_s;
  logic [CHANNELS*QW-1:0] beat_s, q_nxt_s;

  out_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .PW    (PW)
  ) u_mem (
    .clk   (i_clk),
    .we    (wr_ok_s),
    .waddr (wr_ptr_r),
    .wdata (i_d),
    .raddr (rd_ptr_r),
    .rdata (rd_word_s)
  );

  // Per-channel beat selection from the head entry (low half in phase 0).
  always_comb begin
    beat_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      beat_s[c*QW +: QW] = rd_word_s[c*DIN_W + (phase_r ? HOFS : 0) +: QW];
    end
  end

  // Handshake qualification, next count, next phase and next read data.
  always_comb begin
    rd_ok_s = i_rden & ~empty_r;
    if (NARROW_MODE != 0) begin
      pop_s       = rd_ok_s & phase_r;
      phase_nxt_s = rd_ok_s ? ~phase_r : phase_r;
    end else begin
      pop_s       = rd_ok_s;
      phase_nxt_s = 1'b0;
    end
    // A write into a full FIFO only fits if this cycle frees the head slot.
    wr_ok_s = i_wren & (~full_r | pop_s);

    case ({wr_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase

    if (rd_ok_s) begin
      q_nxt_s = beat_s;
    end else if (OUTPUT_DISABLE != 0) begin
      q_nxt_s = '0;
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State and registered outputs; flags follow the next count so they track o_count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      phase_r  <= 1'b0;
      q_r      <= '0;
      empty_r  <= 1'b1;
      ae_r     <= 1'b1;
      full_r   <= 1'b0;
      af_r     <= AF_RST;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      phase_r <= phase_nxt_s;
      q_r     <= q_nxt_s;
      empty_r <= (count_nxt_s == '0);
      ae_r    <= (count_nxt_s <= AE_C);
      full_r  <= (count_nxt_s == DEPTH_C);
      af_r    <= (count_nxt_s >= AF_C);
      ovf_r   <= i_wren & ~wr_ok_s;
      udf_r   <= i_rden & empty_r;
    end
  end

  assign o_q            = q_r;
  assign o_empty        = empty_r;
  assign o_almost_empty = ae_r;
  assign o_full         = full_r;
  assign o_almost_full  = af_r;
  assign o_count        = count_r;
  assign o_overflow     = ovf_r;
  assign o_underflow    = udf_r;

endmodule

// File: tb/tb_out_fifo_sync.sv
// Self-checking bench: a narrow 2-channel instance and a wide 4-channel OUTPUT_DISABLE instance.
module tb_out_fifo_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // narrow instance: 2 ch x 8 bit, DEPTH 8, AE 1, AF 1, NARROW 1, OD 0
  logic        n_rst, n_wren, n_rden;
  logic [15:0] n_d;
  logic [7:0]  n_q;
  logic        n_empty, n_ae, n_full, n_af, n_ovf, n_udf;
  logic [3:0]  n_count;

  // wide instance: 4 ch x 8 bit, DEPTH 8, AE 2, AF 2, NARROW 0, OD 1
  logic        w_rst, w_wren, w_rden;
  logic [31:0] w_d, w_q;
  logic        w_empty, w_ae, w_full, w_af, w_ovf, w_udf;
  logic [3:0]  w_count;

  out_fifo_sync #(.CHANNELS(2), .DIN_W(8), .DEPTH(8), .AE_LEVEL(1), .AF_LEVEL(1),
                  .NARROW_MODE(1), .OUTPUT_DISABLE(0)) dut_n (
    .i_clk(clk), .i_rst(n_rst), .i_wren(n_wren), .i_d(n_d), .i_rden(n_rden),
    .o_q(n_q), .o_empty(n_empty), .o_almost_empty(n_ae), .o_full(n_full),
    .o_almost_full(n_af), .o_count(n_count), .o_overflow(n_ovf), .o_underflow(n_udf));

  out_fifo_sync #(.CHANNELS(4), .DIN_W(8), .DEPTH(8), .AE_LEVEL(2), .AF_LEVEL(2),
                  .NARROW_MODE(0), .OUTPUT_DISABLE(1)) dut_w (
    .i_clk(clk), .i_rst(w_rst), .i_wren(w_wren), .i_d(w_d), .i_rden(w_rden),
    .o_q(w_q), .o_empty(w_empty), .o_almost_empty(w_ae), .o_full(w_full),
    .o_almost_full(w_af), .o_count(w_count), .o_overflow(w_ovf), .o_underflow(w_udf));

  // reference models: queue of stored words plus current output register
  logic [15:0] mn_fifo[$];
  int          mn_beat;
  logic [7:0]  mn_q;
  logic        mn_ovf, mn_udf;
  logic [31:0] mw_fifo[$];
  logic [31:0] mw_q;
  logic        mw_ovf, mw_udf;

  function automatic logic [7:0] half_beat(input logic [15:0] w, input bit hi);
    logic [7:0] r;
    for (int c = 0; c < 2; c++) r[c*4 +: 4] = hi ? w[c*8+4 +: 4] : w[c*8 +: 4];
    return r;
  endfunction

  function automatic logic [15:0] pat(input int i);
    return {4'(7 - i), 4'(i), 4'(15 - i), 4'(i)};
  endfunction

  task automatic step_n(input logic wr, input logic [15:0] d, input logic rd);
    bit rd_ok, pop_e, wr_ok;
    @(negedge clk);
    n_wren = wr; n_d = d; n_rden = rd;
    rd_ok  = rd && (mn_fifo.size() != 0);
    pop_e  = rd_ok && (mn_beat == 1);
    wr_ok  = wr && ((mn_fifo.size() < 8) || pop_e);
    mn_udf = rd && (mn_fifo.size() == 0);
    mn_ovf = wr && !wr_ok;
    if (rd_ok) begin
      mn_q    = half_beat(mn_fifo[0], mn_beat == 1);
      mn_beat = 1 - mn_beat;
    end
    if (pop_e) void'(mn_fifo.pop_front());
    if (wr_ok) mn_fifo.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic step_w(input logic wr, input logic [31:0] d, input logic rd);
    bit rd_ok, wr_ok;
    @(negedge clk);
    w_wren = wr; w_d = d; w_rden = rd;
    rd_ok  = rd && (mw_fifo.size() != 0);
    wr_ok  = wr && ((mw_fifo.size() < 8) || rd_ok);
    mw_udf = rd && (mw_fifo.size() == 0);
    mw_ovf = wr && !wr_ok;
    mw_q   = rd_ok ? mw_fifo[0] : 32'h0;
    if (rd_ok) void'(mw_fifo.pop_front());
    if (wr_ok) mw_fifo.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic model_n_reset();
    mn_fifo.delete(); mn_beat = 0; mn_q = 8'h00; mn_ovf = 1'b0; mn_udf = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    n_rst = 1'b1; w_rst = 1'b1;
    n_wren = 1'b0; n_rden = 1'b0; n_d = 16'h0;
    w_wren = 1'b0; w_rden = 1'b0; w_d = 32'h0;
    model_n_reset();
    mw_fifo.delete(); mw_q = 32'h0; mw_ovf = 1'b0; mw_udf = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0; w_rst = 1'b0;
    #1;
    got = {n_empty, n_ae, n_full, n_af, n_ovf, n_udf, n_count == 4'd0};
    chk_cnt++; if (got !== 7'b1100001 || n_q !== 8'h00) $display("FAIL reset_n flags got=%b q=%h exp=1100001 q=00", got, n_q); else pass_cnt++;
    got = {w_empty, w_ae, w_full, w_af, w_ovf, w_udf, w_count == 4'd0};
    chk_cnt++; if (got !== 7'b1100001 || w_q !== 32'h0) $display("FAIL reset_w flags got=%b q=%h exp=1100001 q=0", got, w_q); else pass_cnt++;
    // mid-stream reset with a half-read entry
    step_n(1'b1, 16'h1234, 1'b0);
    step_n(1'b1, 16'h5678, 1'b0);
    step_n(1'b0, 16'h0, 1'b1);
    @(negedge clk); n_rst = 1'b1; n_rden = 1'b0; #2;
    chk_cnt++; if (n_empty !== 1'b1 || n_count !== 4'd0 || n_q !== 8'h00) $display("FAIL reset_mid got empty=%b count=%0d q=%h exp 1/0/00", n_empty, n_count, n_q); else pass_cnt++;
    @(negedge clk); n_rst = 1'b0;
    model_n_reset();
    step_n(1'b1, 16'hC3E1, 1'b0);
    step_n(1'b0, 16'h0, 1'b1);
    chk_cnt++; if (n_q !== 8'h31) $display("FAIL reset_phase got=%h exp=31", n_q); else pass_cnt++;
    step_n(1'b0, 16'h0, 1'b1);
    chk_cnt++; if (n_q !== 8'hCE || n_empty !== 1'b1) $display("FAIL reset_hi got q=%h empty=%b exp CE/1", n_q, n_empty); else pass_cnt++;
  endtask

  task automatic test_narrow();
    step_n(1'b1, 16'hA55A, 1'b0);
    chk_cnt++; if (n_count !== 4'd1 || n_empty !== 1'b0) $display("FAIL narrow_wr got count=%0d empty=%b exp 1/0", n_count, n_empty); else pass_cnt++;
    step_n(1'b0, 16'h0, 1'b1);
    chk_cnt++; if (n_q !== 8'h5A || n_count !== 4'd1 || n_empty !== 1'b0) $display("FAIL narrow_lo got q=%h count=%0d empty=%b exp 5A/1/0", n_q, n_count, n_empty); else pass_cnt++;
    step_n(1'b0, 16'h0, 1'b1);
    chk_cnt++; if (n_q !== 8'hA5 || n_count !== 4'd0 || n_empty !== 1'b1) $display("FAIL narrow_hi got q=%h count=%0d empty=%b exp A5/0/1", n_q, n_count, n_empty); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      step_n(1'b1, pat(i), 1'b0);
      if (i == 5) begin
        chk_cnt++; if (n_af !== 1'b0) $display("FAIL fill_af6 got=%b exp=0", n_af); else pass_cnt++;
      end
      if (i == 6) begin
        chk_cnt++; if (n_af !== 1'b1 || n_full !== 1'b0) $display("FAIL fill_af7 got af=%b full=%b exp 1/0", n_af, n_full); else pass_cnt++;
      end
    end
    chk_cnt++; if (n_full !== 1'b1 || n_count !== 4'd8) $display("FAIL fill_full got full=%b count=%0d exp 1/8", n_full, n_count); else pass_cnt++;
    step_n(1'b1, pat(8), 1'b0);
    chk_cnt++; if (n_ovf !== 1'b1 || n_count !== 4'd8) $display("FAIL ovf_pulse got ovf=%b count=%0d exp 1/8", n_ovf, n_count); else pass_cnt++;
    step_n(1'b0, 16'h0, 1'b0);
    chk_cnt++; if (n_ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", n_ovf); else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      step_n(1'b0, 16'h0, 1'b1);
      chk_cnt++; if (n_q !== half_beat(pat(k / 2), (k % 2) == 1)) $display("FAIL drain beat=%0d got=%h exp=%h", k, n_q, half_beat(pat(k / 2), (k % 2) == 1)); else pass_cnt++;
    end
    chk_cnt++; if (n_empty !== 1'b1 || n_ae !== 1'b1 || n_count !== 4'd0) $display("FAIL drain_end got empty=%b ae=%b count=%0d exp 1/1/0", n_empty, n_ae, n_count); else pass_cnt++;
  endtask

  task automatic test_full_wr_rd();
    for (int i = 0; i < 8; i++) step_n(1'b1, pat(i + 3), 1'b0);
    step_n(1'b0, 16'h0, 1'b1);
    step_n(1'b1, 16'hBEEF, 1'b1);
    chk_cnt++; if (n_ovf !== 1'b0 || n_count !== 4'd8 || n_full !== 1'b1) $display("FAIL full_wr_rd got ovf=%b count=%0d full=%b exp 0/8/1", n_ovf, n_count, n_full); else pass_cnt++;
    chk_cnt++; if (n_q !== half_beat(pat(3), 1'b1)) $display("FAIL full_wr_rd_q got=%h exp=%h", n_q, half_beat(pat(3), 1'b1)); else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      step_n(1'b0, 16'h0, 1'b1);
      chk_cnt++; if (n_q !== mn_q || n_count !== 4'(mn_fifo.size())) $display("FAIL full_drain beat=%0d got q=%h count=%0d exp q=%h count=%0d", k, n_q, n_count, mn_q, mn_fifo.size()); else pass_cnt++;
    end
    chk_cnt++; if (n_q !== 8'hBE || n_empty !== 1'b1) $display("FAIL full_last got q=%h empty=%b exp BE/1", n_q, n_empty); else pass_cnt++;
  endtask

  task automatic test_underflow();
    logic [7:0]  prev;
    logic [31:0] wd;
    prev = n_q;
    step_n(1'b0, 16'h0, 1'b1);
    chk_cnt++; if (n_udf !== 1'b1 || n_q !== prev || n_count !== 4'd0) $display("FAIL udf_pulse got udf=%b q=%h count=%0d exp 1/%h/0", n_udf, n_q, n_count, prev); else pass_cnt++;
    step_n(1'b0, 16'h0, 1'b0);
    chk_cnt++; if (n_udf !== 1'b0 || n_q !== prev) $display("FAIL udf_clear got udf=%b q=%h exp 0/%h", n_udf, n_q, prev); else pass_cnt++;
    wd = $urandom() | 32'h1;
    step_w(1'b1, wd, 1'b0);
    step_w(1'b0, 32'h0, 1'b1);
    chk_cnt++; if (w_q !== wd) $display("FAIL od_read got=%h exp=%h", w_q, wd); else pass_cnt++;
    step_w(1'b0, 32'h0, 1'b0);
    chk_cnt++; if (w_q !== 32'h0) $display("FAIL od_idle got=%h exp=0", w_q); else pass_cnt++;
  endtask

  task automatic test_random_wide();
    int wp;
    logic [39:0] got, exp;
    int sz;
    wp = 50;
    for (int k = 0; k < 10000; k++) begin
      if (k % 500 == 0) wp = ((k / 500) % 2 == 1) ? 30 : 75;
      step_w($urandom_range(99, 0) < wp, $urandom(), $urandom_range(99, 0) < (105 - wp));
      sz  = mw_fifo.size();
      exp = {mw_q, sz == 0, sz <= 2, sz == 8, sz >= 6, mw_ovf, mw_udf, 2'b00};
      got = {w_q, w_empty, w_ae, w_full, w_af, w_ovf, w_udf, 2'b00};
      chk_cnt++; if (got !== exp || w_count !== 4'(sz)) $display("FAIL rnd_w cyc=%0d got=%h cnt=%0d exp=%h cnt=%0d", k, got, w_count, exp, sz); else pass_cnt++;
    end
  endtask

  task automatic test_random_narrow();
    int wp;
    logic [15:0] got, exp;
    int sz;
    wp = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 300 == 0) wp = ((k / 300) % 2 == 1) ? 25 : 80;
      step_n($urandom_range(99, 0) < wp, 16'($urandom()), $urandom_range(99, 0) < (105 - wp));
      sz  = mn_fifo.size();
      exp = {mn_q, sz == 0, sz <= 1, sz == 8, sz >= 7, mn_ovf, mn_udf, 2'b00};
      got = {n_q, n_empty, n_ae, n_full, n_af, n_ovf, n_udf, 2'b00};
      chk_cnt++; if (got !== exp || n_count !== 4'(sz)) $display("FAIL rnd_n cyc=%0d got=%h cnt=%0d exp=%h cnt=%0d", k, got, n_count, exp, sz); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_fill_drain();
    test_full_wr_rd();
    test_underflow();
    test_random_wide();
    test_random_narrow();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
